// File: rtl/match_ctrl_pkg.sv
// match_ctrl_pkg
//   Shared definitions for the ping-pong match controller: controller FSM
//   states, the game core's FSM codes, serve-player encoding and a few small
//   helpers used by the scoring and LED logic.
package match_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    S_INIT,
    S_READY,
    S_RALLY,
    S_SHOW,
    S_OVER
  } fsm_t;

  // Game core FSM codes as seen on its state output
  typedef enum logic [1:0] {
    CORE_IDLE  = 2'd0,
    CORE_LEFT  = 2'd1,
    CORE_RIGHT = 2'd2,
    CORE_WAIT  = 2'd3
  } core_state_t;

  // Serve / winner encoding, shared with the core's st input
  localparam logic [1:0] PLAYER1 = 2'd0;
  localparam logic [1:0] PLAYER2 = 2'd1;

  // Scores saturate here, and reaching it ends the match outright
  localparam logic [3:0] SCORE_MAX = 4'd15;

  // One-hot ball LED for positions 1..8; anything else shows nothing
  function automatic logic [7:0] posToLed(input logic [3:0] p);
    logic [7:0] r;
    r = 8'h00;
    if (p >= 4'd1 && p <= 4'd8) begin
      r = 8'h01 << (p - 4'd1);
    end
    return r;
  endfunction

  // P1 owns the upper LED half, P2 the lower half
  function automatic logic [7:0] halfLed(input logic [1:0] who);
    return (who == PLAYER2) ? 8'h0F : 8'hF0;
  endfunction

  // A match ends on reaching the target with a two-point lead, or when
  // either side hits the saturation value
  function automatic logic matchDecided(input logic [3:0] a, input logic [3:0] b,
                                        input int target);
    int ia;
    int ib;
    int diff;
    ia   = int'(a);
    ib   = int'(b);
    diff = (ia > ib) ? (ia - ib) : (ib - ia);
    return ((ia >= target || ib >= target) && diff >= 2) ||
           (a == SCORE_MAX) || (b == SCORE_MAX);
  endfunction

endpackage

// File: rtl/match_ctrl_if.sv
// match_ctrl_if
//   Link between the match controller and the ping-pong game core.
//   Core -> controller : win1, win2 (point levels), state (core FSM),
//                        err (wrong-player serve), pos (ball position 1..8)
//   Controller -> core : st (serving player), toIDLE (one-cycle WAIT exit),
//                        game_rst (active-high synchronous core reset)
//   master = controller side, slave = game core side.
interface match_ctrl_if;
  logic       win1;
  logic       win2;
  logic [1:0] state;
  logic       err;
  logic [3:0] pos;
  logic [1:0] st;
  logic       toIDLE;
  logic       game_rst;

  modport master (
    input  win1, win2, state, err, pos,
    output st, toIDLE, game_rst
  );

  modport slave (
    output win1, win2, state, err, pos,
    input  st, toIDLE, game_rst
  );
endinterface

// File: rtl/match_edge.sv
// match_edge
//   Single-bit rising-edge detector: the input is delayed by one register
//   and rise is high for the cycle in which d is high but was low before.
//   Ports: clk, reset (async, active-low), d (level in), rise (edge out).
module match_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  // Remember last cycle's level so a held level produces only one rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/match_ctrl.sv
// match_ctrl
//   Referee for the ping-pong game core: keeps the match score, rotates the
//   serve, shows the ball and point results on 8 LEDs, flags wrong serves
//   and declares the match winner.
//   Ports:
//     clk        system clock shared with the game core
//     reset      asynchronous, active-low, clears everything
//     bus        match_ctrl_if.master link to the game core
//     new_match  button, rising edge starts a fresh match
//     led        ball position / point result display
//     score1/2   player points (saturating at 15)
//     err_led    wrong-serve indicator, held for HOLD cycles
//     champ      00 none, 01 P1 won the match, 10 P2 won the match
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int HOLD    = 8192,
  parameter int BLINK   = 1024,
  parameter int TARGET  = 11,
  parameter int SERVE_N = 2
) (
  input  logic               clk,
  input  logic               reset,
  match_ctrl_if.master       bus,
  input  logic               new_match,
  output logic [7:0]         led,
  output logic [3:0]         score1,
  output logic [3:0]         score2,
  output logic               err_led,
  output logic [1:0]         champ
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int BW = $clog2(BLINK + 1);

  fsm_t          fsm;
  logic          initCnt;
  logic [HW-1:0] holdCnt;
  logic [HW-1:0] errCnt;
  logic [BW-1:0] blinkCnt;
  logic [1:0]    winner;

  logic          riseWin1;
  logic          riseWin2;
  logic          riseErr;
  logic          riseNew;

  logic          pointP1;
  logic          pointP2;
  logic [3:0]    nextS1;
  logic [3:0]    nextS2;
  logic [4:0]    pointTotal;
  logic          serveFlip;
  logic          decided;
  logic [7:0]    winLed;

  match_edge uEdgeWin1 (.clk(clk), .reset(reset), .d(bus.win1),  .rise(riseWin1));
  match_edge uEdgeWin2 (.clk(clk), .reset(reset), .d(bus.win2),  .rise(riseWin2));
  match_edge uEdgeErr  (.clk(clk), .reset(reset), .d(bus.err),   .rise(riseErr));
  match_edge uEdgeNew  (.clk(clk), .reset(reset), .d(new_match), .rise(riseNew));

  // Point bookkeeping: a simultaneous rise from both players is treated as
  // ambiguous and scores nothing. The serve decision uses the total after
  // the new point has been added.
  always_comb begin
    pointP1 = riseWin1 & ~riseWin2;
    pointP2 = riseWin2 & ~riseWin1;
    nextS1  = score1;
    nextS2  = score2;
    if (pointP1 && score1 != SCORE_MAX) begin
      nextS1 = score1 + 4'd1;
    end
    if (pointP2 && score2 != SCORE_MAX) begin
      nextS2 = score2 + 4'd1;
    end
    pointTotal = {1'b0, nextS1} + {1'b0, nextS2};
    serveFlip  = (int'(pointTotal) % SERVE_N) == 0;
    decided    = matchDecided(score1, score2, TARGET);
  end

  assign winLed = halfLed(winner);

  // Main controller FSM. toIDLE defaults low every cycle so any assertion
  // is a single-cycle pulse. A new_match edge wins over everything and
  // restarts the match with the core held in reset for two cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm          <= S_INIT;
      initCnt      <= 1'b0;
      holdCnt      <= '0;
      blinkCnt     <= '0;
      winner       <= PLAYER1;
      score1       <= 4'd0;
      score2       <= 4'd0;
      champ        <= 2'b00;
      led          <= 8'h00;
      bus.st       <= PLAYER1;
      bus.toIDLE   <= 1'b0;
      bus.game_rst <= 1'b1;
    end else begin
      bus.toIDLE <= 1'b0;
      if (riseNew) begin
        fsm          <= S_INIT;
        initCnt      <= 1'b0;
        holdCnt      <= '0;
        blinkCnt     <= '0;
        score1       <= 4'd0;
        score2       <= 4'd0;
        champ        <= 2'b00;
        led          <= 8'h00;
        bus.st       <= PLAYER1;
        bus.game_rst <= 1'b1;
      end else begin
        case (fsm)
          S_INIT: begin
            if (initCnt) begin
              initCnt      <= 1'b0;
              bus.game_rst <= 1'b0;
              fsm          <= S_READY;
            end else begin
              initCnt <= 1'b1;
            end
          end

          S_READY: begin
            led <= 8'h00;
            if (bus.state != CORE_IDLE) begin
              led <= posToLed(bus.pos);
              fsm <= S_RALLY;
            end
          end

          S_RALLY: begin
            if (pointP1 || pointP2) begin
              score1   <= nextS1;
              score2   <= nextS2;
              winner   <= pointP2 ? PLAYER2 : PLAYER1;
              led      <= halfLed(pointP2 ? PLAYER2 : PLAYER1);
              holdCnt  <= '0;
              blinkCnt <= '0;
              fsm      <= S_SHOW;
              if (serveFlip) begin
                bus.st <= (bus.st == PLAYER1) ? PLAYER2 : PLAYER1;
              end
            end else begin
              led <= posToLed(bus.pos);
            end
          end

          S_SHOW: begin
            if (holdCnt == HW'(HOLD - 1)) begin
              holdCnt  <= '0;
              blinkCnt <= '0;
              if (decided) begin
                champ <= (winner == PLAYER2) ? 2'b10 : 2'b01;
                led   <= winLed;
                fsm   <= S_OVER;
              end else begin
                bus.toIDLE <= 1'b1;
                led        <= 8'h00;
                fsm        <= S_READY;
              end
            end else begin
              holdCnt <= holdCnt + 1'b1;
              if (blinkCnt == BW'(BLINK - 1)) begin
                blinkCnt <= '0;
                led      <= (led == 8'h00) ? winLed : 8'h00;
              end else begin
                blinkCnt <= blinkCnt + 1'b1;
              end
            end
          end

          S_OVER: begin
            led <= winLed;
          end

          default: begin
            fsm <= S_INIT;
          end
        endcase
      end
    end
  end

  // Wrong-serve indicator: each new err edge (re)loads a HOLD-cycle timer,
  // independent of the match FSM and never affecting the score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errCnt  <= '0;
      err_led <= 1'b0;
    end else if (riseErr) begin
      errCnt  <= HW'(HOLD);
      err_led <= 1'b1;
    end else if (errCnt != '0) begin
      errCnt  <= errCnt - 1'b1;
      err_led <= (errCnt > HW'(1));
    end
  end

endmodule
